// File: rtl/pop_breeder.sv
// Breeds the next GA population: the sorted parents survive unchanged (elitism),
// and each parent is crossed with its successor, driven by a 16-bit Galois LFSR.
module pop_breeder #(
  parameter int GENE_W    = 30,
  parameter int N_PARENTS = 10
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [N_PARENTS*GENE_W-1:0]     sorted,
  input  logic [15:0]                     seed,
  input  logic                            mutate_en,
  output logic [2*N_PARENTS*GENE_W-1:0]   pop,
  output logic                            busy,
  output logic                            done
);

  localparam int CW = (N_PARENTS > 1) ? $clog2(N_PARENTS) : 1;
  localparam logic [15:0] LFSR_INIT = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [GENE_W-1:0] GENE_ONE = GENE_W'(1);

  typedef enum logic [1:0] {IDLE, BREED, DONE} state_t;

  state_t                      state;
  logic [N_PARENTS*GENE_W-1:0] parents;
  logic                        mut_q;
  logic [15:0]                 lfsr;
  logic [15:0]                 lfsr_next;
  logic [CW-1:0]               idx;
  logic [GENE_W-1:0]           par_a;
  logic [GENE_W-1:0]           par_b;
  logic [GENE_W-1:0]           mask;
  logic [GENE_W-1:0]           child;
  logic [4:0]                  xp;
  logic [4:0]                  mq;

  // Folds a 5-bit LFSR field into a bit position below GENE_W (single subtraction).
  function automatic logic [4:0] reduce_pos(input logic [4:0] v);
    if (int'({27'd0, v}) < GENE_W) return v;
    else return v - 5'(GENE_W);
  endfunction

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block leaves a value held and no latch is inferred.
  always_comb begin
    par_a = '0;
    par_b = '0;
    for (int k = 0; k < N_PARENTS; k++) begin
      if (idx == CW'(k)) begin
        par_a = parents[k*GENE_W +: GENE_W];
        par_b = parents[((k + 1) % N_PARENTS)*GENE_W +: GENE_W];
      end
    end
    xp    = reduce_pos(lfsr[4:0]);
    mq    = reduce_pos(lfsr[9:5]);
    mask  = ~({GENE_W{1'b1}} << xp);
    child = (par_a & mask) | (par_b & ~mask);
    if (mut_q && (lfsr[15:13] == 3'b000)) child = child ^ (GENE_ONE << mq);
    lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      // NOTE: pop is a register bank read combinationally, not a RAM, so it is
      // cleared by reset like any other register.
      pop     <= '0;
      parents <= '0;
      mut_q   <= 1'b0;
      lfsr    <= LFSR_INIT;
      idx     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            parents                     <= sorted;
            mut_q                       <= mutate_en;
            lfsr                        <= (seed == 16'h0000) ? LFSR_INIT : seed;
            pop[N_PARENTS*GENE_W-1:0]   <= sorted;
            idx                         <= '0;
            busy                        <= 1'b1;
            state                       <= BREED;
          end
        end
        BREED: begin
          for (int k = 0; k < N_PARENTS; k++) begin
            if (idx == CW'(k)) pop[(N_PARENTS + k)*GENE_W +: GENE_W] <= child;
          end
          lfsr <= lfsr_next;
          if (idx == CW'(N_PARENTS - 1)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            idx <= idx + CW'(1);
          end
        end
        DONE: begin
          // start is deliberately not looked at here.
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pop_breeder.sv
// Self-checking bench for pop_breeder: directed scenarios plus randomized
// generations compared against an arithmetic model of the breeding rules.
module tb_pop_breeder;

  localparam int G  = 30;
  localparam int N  = 10;
  localparam int SW = N * G;
  localparam int PW = 2 * N * G;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [SW-1:0] sorted = '0;
  logic [15:0]   seed = '0;
  logic          mutate_en = 1'b0;
  logic [PW-1:0] pop;
  logic          busy;
  logic          done;

  int checks = 0;
  int failures = 0;

  pop_breeder #(.GENE_W(G), .N_PARENTS(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sorted(sorted), .seed(seed),
    .mutate_en(mutate_en), .pop(pop), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference: elite copy, then per-child crossover/mutation from the LFSR value.
  function automatic logic [PW-1:0] model(input logic [SW-1:0] s, input logic [15:0] sd,
                                          input logic m);
    logic [PW-1:0] res;
    logic [G-1:0]  a, b, c;
    int unsigned   lv, p, q;
    res = '0;
    lv  = (sd == 16'h0000) ? 32'hACE1 : {16'h0, sd};
    for (int k = 0; k < N; k++) res[k*G +: G] = s[k*G +: G];
    for (int j = 0; j < N; j++) begin
      a = s[j*G +: G];
      b = s[((j + 1) % N)*G +: G];
      p = lv % 32;
      if (p >= G) p = p - G;
      q = (lv / 32) % 32;
      if (q >= G) q = q - G;
      for (int bt = 0; bt < G; bt++) c[bt] = (bt < p) ? a[bt] : b[bt];
      if (m && (lv / 8192) == 0) c[q] = ~c[q];
      res[(N + j)*G +: G] = c;
      lv = (lv / 2) ^ ((lv % 2) ? 32'hB400 : 32'h0);
    end
    return res;
  endfunction

  function automatic logic [SW-1:0] rand_parents();
    logic [SW-1:0] s;
    for (int k = 0; k < N; k++) s[k*G +: G] = G'($urandom);
    return s;
  endfunction

  // Starts a generation, scrambles inputs right after the start edge, and returns
  // the number of rising edges after the start edge until done (-1 on timeout).
  // Returns once the FSM is back in IDLE.
  task automatic run_gen(input logic [SW-1:0] s, input logic [15:0] sd, input logic m,
                         output int lat);
    @(negedge clk);
    sorted = s; seed = sd; mutate_en = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; sorted = ~s; seed = ~sd; mutate_en = ~m;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done) begin lat = n; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (pop !== '0) begin failures++; $display("FAIL reset_pop: got %h expected 0", pop); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  // Even parents all ones, odd parents zero; seed 1.
  task automatic test_crossover(input logic m);
    logic [SW-1:0] s;
    int lat;
    logic [G-1:0] exp10;
    for (int k = 0; k < N; k++) s[k*G +: G] = (k % 2 == 0) ? {G{1'b1}} : '0;
    run_gen(s, 16'h0001, m, lat);
    // done in cycle N+1 when the start cycle is counted as cycle 0
    checks++; if (lat !== N) begin failures++; $display("FAIL xover_latency: got %0d expected %0d", lat, N); end
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++;
      $display("FAIL xover_idle_after_done: got done=%b busy=%b expected 0 0", done, busy); end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (pop[k*G +: G] !== s[k*G +: G]) begin failures++;
        $display("FAIL elite_child%0d: got %h expected %h", k, pop[k*G +: G], s[k*G +: G]); end
    end
    exp10 = m ? 30'h0000_0000 : 30'h0000_0001;
    checks++; if (pop[10*G +: G] !== exp10) begin failures++;
      $display("FAIL child10 mut=%b: got %h expected %h", m, pop[10*G +: G], exp10); end
    checks++; if (pop[11*G +: G] !== 30'h3FFF_FFFF) begin failures++;
      $display("FAIL child11 mut=%b: got %h expected 3fffffff", m, pop[11*G +: G]); end
    checks++; if (pop !== model(s, 16'h0001, m)) begin failures++;
      $display("FAIL xover_pop mut=%b: got %h expected %h", m, pop, model(s, 16'h0001, m)); end
  endtask

  task automatic test_zero_seed();
    logic [SW-1:0] s;
    logic [PW-1:0] p0;
    int lat;
    s = rand_parents();
    run_gen(s, 16'h0000, 1'b1, lat);
    p0 = pop;
    checks++; if (p0 !== model(s, 16'hACE1, 1'b1)) begin failures++;
      $display("FAIL zero_seed_pop: got %h expected %h", p0, model(s, 16'hACE1, 1'b1)); end
    run_gen(s, 16'hACE1, 1'b1, lat);
    checks++; if (pop !== p0) begin failures++;
      $display("FAIL zero_seed_vs_ace1: got %h expected %h", pop, p0); end
  endtask

  task automatic test_busy_ignore();
    logic [SW-1:0] s;
    logic [15:0]   sd;
    int done_cnt;
    s = rand_parents();
    sd = 16'h1234;
    done_cnt = 0;
    @(negedge clk);
    sorted = s; seed = sd; mutate_en = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      start = (n == 3 || n == 11);
      if (n == 2) begin sorted = rand_parents(); seed = 16'hBEEF; mutate_en = 1'b0; end
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    @(negedge clk); start = 1'b0;
    checks++; if (done_cnt !== 1) begin failures++;
      $display("FAIL busy_done_count: got %0d expected 1", done_cnt); end
    checks++; if (busy !== 1'b0) begin failures++;
      $display("FAIL busy_start_in_done: got busy=%b expected 0", busy); end
    checks++; if (pop !== model(s, sd, 1'b1)) begin failures++;
      $display("FAIL busy_pop: got %h expected %h", pop, model(s, sd, 1'b1)); end
  endtask

  task automatic test_reset_mid();
    logic [SW-1:0] s;
    int lat;
    s = rand_parents();
    @(negedge clk);
    sorted = s; seed = 16'h0F0F; mutate_en = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (pop !== '0) begin failures++; $display("FAIL midrst_pop: got %h expected 0", pop); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++;
      $display("FAIL midrst_flags: got busy=%b done=%b expected 0 0", busy, done); end
    @(negedge clk); rst_n = 1'b1;
    s = rand_parents();
    run_gen(s, 16'h5A5A, 1'b1, lat);
    checks++; if (lat !== N) begin failures++; $display("FAIL midrst_latency: got %0d expected %0d", lat, N); end
    checks++; if (pop !== model(s, 16'h5A5A, 1'b1)) begin failures++;
      $display("FAIL midrst_pop_after: got %h expected %h", pop, model(s, 16'h5A5A, 1'b1)); end
  endtask

  task automatic test_random();
    logic [SW-1:0] s;
    logic [15:0]   sd;
    logic          m;
    int lat;
    for (int i = 0; i < 200; i++) begin
      s  = rand_parents();
      sd = ($urandom_range(0, 15) == 0) ? 16'h0000 : 16'($urandom);
      m  = 1'($urandom_range(0, 1));
      run_gen(s, sd, m, lat);
      checks++; if (lat !== N) begin failures++;
        $display("FAIL rand%0d_latency: got %0d expected %0d", i, lat, N); end
      checks++; if (pop !== model(s, sd, m)) begin failures++;
        $display("FAIL rand%0d_pop seed=%h mut=%b: got %h expected %h", i, sd, m, pop, model(s, sd, m)); end
    end
  endtask

  initial begin
    test_reset();
    test_crossover(1'b0);
    test_crossover(1'b1);
    test_zero_seed();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pop_breeder.md
POP_BREEDER -- requirements
Module: pop_breeder

Interface
REQ-001 Parameter GENE_W, default 30, sets the width of one chromosome in bits.
REQ-002 Parameter N_PARENTS, default 10, sets the number of sorted parents; the population size is 2*N_PARENTS.
REQ-003 clk  input  1  single clock; all registers sample on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to breed a new generation.
REQ-006 sorted  input  N_PARENTS*GENE_W (300)  parents from the sorter, fittest first; parent k = sorted[k*GENE_W +: GENE_W].
REQ-007 seed  input  16  LFSR seed, sampled with start.
REQ-008 mutate_en  input  1  mutation enable, sampled with start.
REQ-009 pop  output  2*N_PARENTS*GENE_W (600)  next population; child k = pop[k*GENE_W +: GENE_W].
REQ-010 busy  output  1  high while breeding.
REQ-011 done  output  1  one-cycle pulse when pop is complete.

Function
REQ-012 The FSM SHALL have three states: IDLE, BREED, DONE.
REQ-013 In IDLE, start=1 SHALL do all of the following at that edge (cycle 0):
- latch sorted into the parent register;
- latch mutate_en;
- load the LFSR with seed, or 16'hACE1 if seed==0;
- write children 0..N_PARENTS-1 = parents 0..N_PARENTS-1 (elitism);
- enter BREED.
REQ-014 BREED SHALL last exactly N_PARENTS cycles; in BREED cycle j (j=0..N_PARENTS-1) it SHALL write child N_PARENTS+j, then advance the LFSR.
REQ-015 LFSR SHALL be 16-bit Galois: next = (L>>1) ^ (L[0] ? 16'hB400 : 16'h0000).
REQ-016 Parent selection for child N_PARENTS+j: A = parent j, B = parent (j+1) mod N_PARENTS.
REQ-017 Crossover point p = L[4:0] if < GENE_W, else L[4:0]-GENE_W.
- mask = low p bits set.
- child = (A & mask) | (B & ~mask); p=0 yields B.
REQ-018 Mutation: if the latched mutate_en=1 and L[15:13]==3'b000, the crossover result SHALL have bit q inverted.
- q = L[9:5] reduced the same way as p.
REQ-019 After the last BREED cycle, the FSM SHALL enter DONE for exactly one cycle with done=1, then return to IDLE.
REQ-020 With the default parameters, done SHALL be high in cycle N_PARENTS+1 = 11 after the start edge.
REQ-021 busy SHALL be 1 in BREED and DONE and 0 in IDLE.
REQ-022 start SHALL be ignored unless the FSM is in IDLE; in particular, start during DONE has no effect.
REQ-023 Changes on sorted, seed and mutate_en after the start edge SHALL NOT affect the current generation.
REQ-024 pop SHALL hold its value from done until the next accepted start; contents during BREED are partial and not guaranteed.
REQ-025 All arithmetic SHALL be unsigned, with widths derived from the parameters; no width truncation beyond GENE_W per child.

Reset
REQ-026 rst_n=0 SHALL force, asynchronously:
- state to IDLE;
- pop, parent register and mutate latch to 0;
- LFSR to 16'hACE1;
- busy=0 and done=0.
REQ-027 Reset asserted mid-BREED SHALL abort the generation; no done pulse is produced and pop reads 0.
REQ-028 After reset is released, the first rising edge with start=1 SHALL be accepted.

Verification
REQ-029 Elitism and crossover:
- stimulus: even parents 0x3FFFFFFF, odd parents 0; seed=16'h0001; mutate_en=0; start pulse.
- response: done at cycle 11; children 0..9 = inputs; child10 = 0x00000001 (p=1); child11 = parent2 = 0x3FFFFFFF (L=0xB400, p=0).
REQ-030 Mutation:
- stimulus: same as REQ-029 but mutate_en=1.
- response: child10 = 0x00000000 (L=0x0001, so q=0 flips bit 0); child11 unchanged (L[15:13]=3'b101).
REQ-031 Zero seed:
- stimulus: seed=0.
- response: sequence identical to seed=16'hACE1; check against a reference model.
REQ-032 Busy and ignored start:
- stimulus: pulse start again at cycles 3 and 11 while busy; change sorted and seed at cycle 2.
- response: exactly one done pulse; pop identical to the undisturbed run.
REQ-033 Reset mid-operation:
- stimulus: assert rst_n=0 at cycle 5 of BREED.
- response: immediately pop=0, busy=0, done=0, state IDLE; a new start then completes normally in 11 cycles.
REQ-034 Randomized check:
- stimulus: 200 random sorted/seed/mutate_en sets.
- response: pop matches the bit-exact model of REQ-015..REQ-018.
